// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares port A of the 128k RAM between the CPU memory path (mmap) and a DMA
// requester. DMA accesses use CPU-idle slots, where hold_in = 0.
//
// Optional feature macro RAMARB_STEAL_EN: after STARVE waiting cycles, a DMA
// request may take a slot in which the CPU could have stepped. The CPU is then
// owed that step (debt), and gets it back in the next non-DMA cycle.
//
// Ports:
//   clock, reset_n           CPU clock; synchronous active-low reset
//   hold_in / hold_out       raw hold from clockdiv / gated hold to z80 + mmap
//   cpu_address/data/we      CPU side of the RAM port (from mmap)
//   dma_req/we/address/data  DMA request, held stable until dma_ack
//   dma_ack                  one-cycle pulse; the DMA access owns the RAM port
//   dma_q / dma_valid        registered read data and its one-cycle strobe
//   ram_address/data/we      to ram128 port A
//   ram_q                    ram128 q_a; valid one clock after the address
module ram_arbiter #(
    parameter int unsigned STARVE = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        hold_in,
    output logic        hold_out,
    input  logic [16:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_we,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [16:0] dma_address,
    input  logic [7:0]  dma_data,
    output logic        dma_ack,
    output logic [7:0]  dma_q,
    output logic        dma_valid,
    output logic [16:0] ram_address,
    output logic [7:0]  ram_data,
    output logic        ram_we,
    input  logic [7:0]  ram_q
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDma  = 2'd1,
        StRd   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        valid_q, valid_d;
    logic        grant;
    logic        hold_gated;

`ifdef RAMARB_STEAL_EN
    localparam logic [7:0] StarveMax = 8'(STARVE);

    logic        debt_q, debt_d;
    logic [7:0]  starve_q, starve_d;

    always_comb begin
        grant      = dma_req && !debt_q && (!hold_in || (starve_q == StarveMax));
        hold_gated = hold_in | debt_q;
    end

    always_comb begin
        starve_d = starve_q;
        if (!dma_req) begin
            starve_d = 8'd0;
        end else if (state_q == StIdle) begin
            if (grant) begin
                starve_d = 8'd0;
            end else if (starve_q < StarveMax) begin
                starve_d = starve_q + 8'd1;
            end
        end
        // A swallowed step (S_DMA with hold_in) becomes debt; while paying a
        // debt back, a coincident new hold pulse is carried forward.
        debt_d = ((state_q == StDma) || debt_q) ? hold_in : 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            debt_q   <= 1'b0;
            starve_q <= 8'd0;
        end else begin
            debt_q   <= debt_d;
            starve_q <= starve_d;
        end
    end
`else
    always_comb begin
        grant      = dma_req && !hold_in;
        hold_gated = hold_in;
    end
`endif

    // Next state and read capture
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StDma;
                end
            end
            StDma: begin
                state_d = dma_we ? StIdle : StRd;
            end
            StRd: begin
                // ram_q now carries the word addressed during StDma
                state_d = StIdle;
                rdata_d = ram_q;
                valid_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            rdata_q <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    // Port mux and gated hold; hold and write strobe are killed during reset
    always_comb begin
        hold_out = reset_n && (state_q != StDma) && hold_gated;
        if (state_q == StDma) begin
            ram_address = dma_address;
            ram_data    = dma_data;
            ram_we      = reset_n && dma_we;
        end else begin
            ram_address = cpu_address;
            ram_data    = cpu_data;
            ram_we      = reset_n && cpu_we && hold_out;
        end
    end

    assign dma_ack   = (state_q == StDma);
    assign dma_q     = rdata_q;
    assign dma_valid = valid_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter. Directed stimulus pushes expected
// RAM-port contents (on dma_ack) and read data (on dma_valid) into queues; a
// negedge monitor pops and compares. Built with or without RAMARB_STEAL_EN.
module tb_ram_arbiter;
    localparam int unsigned Starve = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        hold_in;
    logic        hold_out;
    logic [16:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic        dma_req;
    logic        dma_we;
    logic [16:0] dma_address;
    logic [7:0]  dma_data;
    logic        dma_ack;
    logic [7:0]  dma_q;
    logic        dma_valid;
    logic [16:0] ram_address;
    logic [7:0]  ram_data;
    logic        ram_we;
    logic [7:0]  ram_q;

    always #5 clock = ~clock;

    ram_arbiter #(.STARVE(Starve)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .hold_in     (hold_in),
        .hold_out    (hold_out),
        .cpu_address (cpu_address),
        .cpu_data    (cpu_data),
        .cpu_we      (cpu_we),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_address (dma_address),
        .dma_data    (dma_data),
        .dma_ack     (dma_ack),
        .dma_q       (dma_q),
        .dma_valid   (dma_valid),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_we      (ram_we),
        .ram_q       (ram_q)
    );

    // ram128 port A: registered output
    logic [7:0] mem [0:131071];
    always @(posedge clock) begin
        if (ram_we === 1'b1) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        logic        we;
    } ack_t;

    ack_t       ack_q[$];
    logic [7:0] valid_q[$];

    // Monitor
    always @(negedge clock) begin : monitor
        ack_t       e;
        logic [7:0] d;
        if (dma_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", {31'b0, dma_ack}, 32'd0);
            end else begin
                e = ack_q.pop_front();
                check("ack_ram_address", {15'b0, ram_address}, {15'b0, e.addr});
                check("ack_ram_we", {31'b0, ram_we}, {31'b0, e.we});
                if (e.we) check("ack_ram_data", {24'b0, ram_data}, {24'b0, e.data});
            end
        end
        if (dma_valid === 1'b1) begin
            if (valid_q.size() == 0) begin
                check("unexpected_valid", {31'b0, dma_valid}, 32'd0);
            end else begin
                d = valid_q.pop_front();
                check("valid_dma_q", {24'b0, dma_q}, {24'b0, d});
            end
        end
    end

    // Hold pulse counters
    logic count_en = 1'b0;
    int   in_cnt = 0;
    int   out_cnt = 0;
    always @(negedge clock) begin
        if (count_en) begin
            in_cnt  += int'(hold_in);
            out_cnt += int'(hold_out);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns the negedge index (0 = first) at which dma_ack was seen, or -1
    task automatic wait_ack(output int lat);
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (dma_ack === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_read(input logic [16:0] addr, input logic [7:0] exp,
                           input logic [16:0] cpu_addr);
        int   lat;
        ack_t e;
        dma_req     = 1'b1;
        dma_we      = 1'b0;
        dma_address = addr;
        hold_in     = 1'b0;
        cpu_address = cpu_addr;
        cpu_we      = 1'b0;
        e.addr = addr;
        e.data = dma_data;
        e.we   = 1'b0;
        ack_q.push_back(e);
        valid_q.push_back(exp);
        wait_ack(lat);
        check("rd_ack_latency", lat, 1);
        step();
        dma_req = 1'b0;
        hold_in = 1'b1;
        @(negedge clock);
        check("rd_srd_ram_address", {15'b0, ram_address}, {15'b0, cpu_addr});
        check("rd_srd_hold_out", {31'b0, hold_out}, 32'd1);
        step();
        hold_in = 1'b0;
        @(negedge clock);
        check("rd_valid_timing", {31'b0, dma_valid}, 32'd1);
        step();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   lat;
        int   first;
        int   mism;
        logic ack_hold;
        ack_t e;

        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[17'h00010] = 8'hA7;

        // 1: reset with a pending request and hold_in = 1
        reset_n     = 1'b0;
        hold_in     = 1'b1;
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 17'h1C000;
        dma_data    = 8'h5A;
        cpu_address = 17'h00123;
        cpu_data    = 8'h11;
        cpu_we      = 1'b1;
        step();
        step();
        @(negedge clock);
        check("rst_hold_out", {31'b0, hold_out}, 32'd0);
        check("rst_ram_we", {31'b0, ram_we}, 32'd0);
        check("rst_dma_ack", {31'b0, dma_ack}, 32'd0);
        check("rst_dma_valid", {31'b0, dma_valid}, 32'd0);
        check("rst_dma_q", {24'b0, dma_q}, 32'd0);
        step();
        reset_n = 1'b1;
        dma_req = 1'b0;
        cpu_we  = 1'b0;
        @(negedge clock);
        check("post_rst_hold_high", {31'b0, hold_out}, 32'd1);
        step();
        hold_in = 1'b0;
        @(negedge clock);
        check("post_rst_hold_low", {31'b0, hold_out}, 32'd0);

        // 2: DMA write 0x5A -> 0x1C000 in a hold_in = 0 slot
        step();
        in_cnt   = 0;
        out_cnt  = 0;
        count_en = 1'b1;
        hold_in  = 1'b1;
        cpu_we   = 1'b1;
        step();
        hold_in     = 1'b0;
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 17'h1C000;
        dma_data    = 8'h5A;
        e.addr = 17'h1C000;
        e.data = 8'h5A;
        e.we   = 1'b1;
        ack_q.push_back(e);
        wait_ack(lat);
        check("wr_ack_latency", lat, 1);
        check("wr_dma_hold_out", {31'b0, hold_out}, 32'd0);
        step();
        dma_req = 1'b0;
        hold_in = 1'b1;
        step();
        hold_in = 1'b0;
        step();
        count_en = 1'b0;
        check("wr_cpu_steps", out_cnt, 2);

        // 3: reads, including read-back of the write above
        do_read(17'h00010, 8'hA7, 17'h00456);
        do_read(17'h1C000, 8'h5A, 17'h00789);

        // 4/5: hold_in tied high with a request held
        hold_in     = 1'b1;
        cpu_we      = 1'b0;
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 17'h00200;
        dma_data    = 8'h33;
`ifdef RAMARB_STEAL_EN
        e.addr = 17'h00200;
        e.data = 8'h33;
        e.we   = 1'b1;
        ack_q.push_back(e);
`endif
        in_cnt   = 0;
        out_cnt  = 0;
        count_en = 1'b1;
        first    = -1;
        mism     = 0;
        ack_hold = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (dma_ack === 1'b1 && first < 0) begin
                first    = n;
                ack_hold = hold_out;
            end
            if (hold_out !== hold_in) mism++;
            step();
            if (first >= 0) dma_req = 1'b0;
        end
        count_en = 1'b0;
        dma_req  = 1'b0;
`ifdef RAMARB_STEAL_EN
        check("steal_grant_cycle", first, 5);
        check("steal_ack_hold_out", {31'b0, ack_hold}, 32'd0);
        check("steal_hold_out_count", out_cnt, 99);
        hold_in = 1'b0;
        @(negedge clock);
        check("steal_debt_payback", {31'b0, hold_out}, 32'd1);
        step();
        @(negedge clock);
        check("steal_debt_cleared", {31'b0, hold_out}, 32'd0);
        step();
`else
        check("nosteal_no_ack", first, -1);
        check("nosteal_hold_mismatch", mism, 0);
        check("nosteal_hold_out_count", out_cnt, 100);
        hold_in = 1'b0;
        step();
`endif

        // 6: reset asserted during S_RD
        dma_req     = 1'b1;
        dma_we      = 1'b0;
        dma_address = 17'h00010;
        hold_in     = 1'b0;
        e.addr = 17'h00010;
        e.data = dma_data;
        e.we   = 1'b0;
        ack_q.push_back(e);
        wait_ack(lat);
        check("rstrd_ack_latency", lat, 1);
        step();
        dma_req = 1'b0;
        reset_n = 1'b0;
        step();
        @(negedge clock);
        check("rstrd_dma_valid", {31'b0, dma_valid}, 32'd0);
        check("rstrd_dma_q", {24'b0, dma_q}, 32'd0);
        check("rstrd_dma_ack", {31'b0, dma_ack}, 32'd0);
        step();
        reset_n = 1'b1;
        @(negedge clock);
        check("rstrd_no_late_valid", {31'b0, dma_valid}, 32'd0);

        // Back in S_IDLE: a fresh write is granted with normal latency
        step();
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 17'h00300;
        dma_data    = 8'hC3;
        e.addr = 17'h00300;
        e.data = 8'hC3;
        e.we   = 1'b1;
        ack_q.push_back(e);
        wait_ack(lat);
        check("after_rst_wr_latency", lat, 1);
        step();
        dma_req = 1'b0;
        repeat (4) step();

        check("ack_queue_drained", ack_q.size(), 0);
        check("valid_queue_drained", valid_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
